// File: rtl/key_scan_if.sv
// Key-matrix and event bus for key_scan.
// The master side is the scanner; the slave side is the matrix and event consumer.
interface key_scan_if;
  logic [7:0]  key_col;
  logic [7:0]  key_row;
  logic [63:0] key_state;
  logic        ev_valid;
  logic [6:0]  ev_data;
  logic        ev_ready;
  logic        scan_done;

  modport master (
    output key_col, key_state, ev_valid, ev_data, scan_done,
    input  key_row, ev_ready
  );

  modport slave (
    input  key_col, key_state, ev_valid, ev_data, scan_done,
    output key_row, ev_ready
  );
endinterface

// File: rtl/key_scan.sv
// 8x8 key-matrix scanner with per-key frame debounce and an optional make/break event FIFO.
// Define KEY_SCAN_EVENT_FIFO_EN to build the 8-deep event FIFO; otherwise the event outputs are tied off.
module key_scan #(
  parameter int unsigned SETTLE   = 4,
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      ce_i,
  input  logic      enable_i,
  key_scan_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE
  } state_e;

  state_e      state_q;
  logic [2:0]  col_q;
  logic [2:0]  row_q;
  logic [3:0]  settle_q;
  logic [7:0]  key_col_q;
  logic [63:0] key_state_q;
  logic [1:0]  cnt_q [64];
  logic        scan_done_q;

  logic [5:0]  key_idx;
  logic        sample_bit;
  logic [2:0]  cnt_next;
  logic        mismatch;
  logic        ev_due;
  logic        push_ok;
  logic        stall;
  logic [2:0]  col_nxt;

  always_comb begin
    key_idx    = {col_q, row_q};
    sample_bit = ~bus.key_row[row_q];
    cnt_next   = {1'b0, cnt_q[key_idx]} + 3'd1;
    mismatch   = (state_q == ST_SAMPLE) && (sample_bit != key_state_q[key_idx]);
    ev_due     = mismatch && (cnt_next == 3'(DEBOUNCE));
    stall      = ev_due && !push_ok;
    col_nxt    = col_q + 3'd1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      col_q       <= 3'd0;
      row_q       <= 3'd0;
      settle_q    <= 4'd0;
      key_col_q   <= 8'hFF;
      key_state_q <= 64'd0;
      scan_done_q <= 1'b0;
      for (int i = 0; i < 64; i++) cnt_q[i] <= 2'd0;
    end else if (ce_i) begin
      scan_done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (enable_i) begin
            state_q   <= ST_SETTLE;
            col_q     <= 3'd0;
            row_q     <= 3'd0;
            settle_q  <= 4'd0;
            key_col_q <= 8'hFE;
          end
        end
        ST_SETTLE: begin
          if (!enable_i) begin
            state_q   <= ST_IDLE;
            settle_q  <= 4'd0;
            key_col_q <= 8'hFF;
          end else if (settle_q == 4'(SETTLE - 1)) begin
            state_q  <= ST_SAMPLE;
            row_q    <= 3'd0;
            settle_q <= 4'd0;
          end else begin
            settle_q <= settle_q + 4'd1;
          end
        end
        ST_SAMPLE: begin
          // A due event with no FIFO room holds everything on this row until it can be pushed.
          if (!stall) begin
            if (!mismatch) begin
              cnt_q[key_idx] <= 2'd0;
            end else if (ev_due) begin
              key_state_q[key_idx] <= sample_bit;
              cnt_q[key_idx]       <= 2'd0;
            end else begin
              cnt_q[key_idx] <= cnt_next[1:0];
            end
            row_q <= row_q + 3'd1;
            if (row_q == 3'd7) begin
              col_q       <= col_nxt;
              scan_done_q <= (col_q == 3'd7);
            end
            if (!enable_i) begin
              state_q   <= ST_IDLE;
              row_q     <= 3'd0;
              key_col_q <= 8'hFF;
            end else if (row_q == 3'd7) begin
              state_q   <= ST_SETTLE;
              key_col_q <= ~(8'h01 << col_nxt);
            end
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          key_col_q <= 8'hFF;
        end
      endcase
    end
  end

  assign bus.key_col   = key_col_q;
  assign bus.key_state = key_state_q;
  assign bus.scan_done = scan_done_q;

`ifdef KEY_SCAN_EVENT_FIFO_EN
  logic [6:0] fifo_mem [8];
  logic [2:0] wr_ptr_q;
  logic [2:0] rd_ptr_q;
  logic [3:0] count_q;
  logic       push;
  logic       pop;

  // Room is judged on registered occupancy; a same-cycle pop does not free a slot.
  assign push_ok = ~count_q[3];
  assign push    = ev_due && push_ok;
  assign pop     = (count_q != 4'd0) && bus.ev_ready && ce_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= 3'd0;
      rd_ptr_q <= 3'd0;
      count_q  <= 4'd0;
    end else if (ce_i) begin
      if (push) wr_ptr_q <= wr_ptr_q + 3'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 3'd1;
      count_q <= count_q + 4'(push) - 4'(pop);
    end
  end

  // NOTE: storage is not reset; occupancy gates what is visible, so stale entries never escape.
  always_ff @(posedge clk_i) begin
    if (ce_i && push) fifo_mem[wr_ptr_q] <= {sample_bit, key_idx};
  end

  assign bus.ev_valid = (count_q != 4'd0);
  assign bus.ev_data  = (count_q != 4'd0) ? fifo_mem[rd_ptr_q] : 7'd0;
`else
  assign push_ok      = 1'b1;
  assign bus.ev_valid = 1'b0;
  assign bus.ev_data  = 7'd0;
`endif

endmodule

// File: doc/key_scan.md
KEY_SCAN -- requirements
Module: key_scan

Interface
REQ-001 Parameter SETTLE, default 4: CE cycles a column is driven before its rows are sampled (range 1-15).
REQ-002 Parameter DEBOUNCE, default 3: consecutive differing frame samples needed to flip a key's state (range 1-3).
REQ-003 CLK  in  1  system clock; single clock domain.
REQ-004 RST  in  1  reset; synchronous, active-high.
REQ-005 CE  in  1  clock enable; all state advances only on CLK edges with CE=1.
REQ-006 ENABLE  in  1  scan enable; 0 parks the scanner.
REQ-007 KEY_COL  out  8  column drive to the key matrix; active-low, at most one bit low.
REQ-008 KEY_ROW  in  8  row readback from the key matrix; 0 = key shorting that row to the driven column.
REQ-009 KEY_STATE  out  64  debounced key map; bit col*8+row, 1 = pressed.
REQ-010 EV_VALID  out  1  key event available at FIFO head.
REQ-011 EV_DATA  out  7  event {press, col[2:0], row[2:0]}; press 1 = make, 0 = break.
REQ-012 EV_READY  in  1  consumer accepts the head event when EV_VALID=1 and CE=1.
REQ-013 SCAN_DONE  out  1  one-CE-cycle pulse after the last row of column 7 is processed.

Function
REQ-014 FSM states: IDLE, SETTLE, SAMPLE; column counter col (3 bits), row counter row (3 bits), settle counter (4 bits).
REQ-015 IDLE: KEY_COL=8'hFF; when ENABLE=1, load col=0 and go to SETTLE.
REQ-016 SETTLE: KEY_COL=~(8'h01<<col); count SETTLE CE cycles, then go to SAMPLE with row=0.
REQ-017 SAMPLE: KEY_COL unchanged; process one row per CE cycle, row 0 to 7; after row 7, col increments (7 wraps to 0) and the FSM returns to SETTLE.
REQ-018 Frame length: 8*(SETTLE+8) CE cycles with no stalls; 96 at defaults.
REQ-019 Processing key k=col*8+row: sample s=~KEY_ROW[row]; if s==KEY_STATE[k], clear cnt[k] (2 bits); else increment cnt[k]; when cnt[k] would reach DEBOUNCE, invert KEY_STATE[k], clear cnt[k], and push event {s,col,row}.
REQ-020 Each key is evaluated once per frame, so debounce time is DEBOUNCE frames; at most one event is generated per cycle.
REQ-021 FIFO is 8 entries deep, first-in first-out; pop when EV_VALID & EV_READY & CE.
REQ-022 Push is allowed only when the registered occupancy is below 8; a simultaneous pop does not free a slot in the same cycle.
REQ-023 If an event is due and the FIFO is full, SAMPLE stalls on the current row: no counter or state update, KEY_COL held; retry on the next CE cycle; events are never dropped.
REQ-024 ENABLE=0 in SETTLE or SAMPLE: the current row completes if it is in SAMPLE, then the FSM goes to IDLE at the next CE; KEY_STATE, cnt and FIFO are retained; a later restart begins at col 0.
REQ-025 SCAN_DONE pulses on the CE cycle that completes row 7 of column 7, and never during a stall.
REQ-026 CE=0 freezes all registers and outputs.

Reset
REQ-027 RST=1 at a CLK edge forces, regardless of CE: state IDLE, col=row=settle=0, KEY_COL=8'hFF, KEY_STATE=0, all cnt=0, FIFO empty, EV_VALID=0, EV_DATA=0, SCAN_DONE=0.
REQ-028 RST during a stall or mid-frame discards pending events; the first frame after reset starts at col 0.

Configuration
REQ-029 Macro KEY_SCAN_EVENT_FIFO_EN defined: the FIFO and event outputs behave as in REQ-019 to REQ-023.
REQ-030 Macro not defined: no FIFO is built; EV_VALID=0 and EV_DATA=0 constantly; EV_READY is ignored; SAMPLE never stalls; KEY_STATE behaviour is unchanged.

Verification (defaults SETTLE=4, DEBOUNCE=3; matrix model returns row r low when KEY_COL[c]=0 and key (c,r) is held)
REQ-031 Apply RST for 1 cycle, then ENABLE=0 -> KEY_COL=FF, KEY_STATE=0, EV_VALID=0, SCAN_DONE=0 indefinitely.
REQ-032 ENABLE=1, CE=1, no keys held -> SCAN_DONE pulses every 96 cycles; KEY_COL steps FE,FD,...,7F, each column held 12 cycles.
REQ-033 Hold key (2,6) for 4 frames -> KEY_STATE bit 22 sets at the 3rd frame's sample; exactly one event 7'h56; releasing for 3 frames gives 7'h16.
REQ-034 Hold key (2,6) for only 2 frames -> no event, KEY_STATE stays 0, cnt returns to 0.
REQ-035 EV_READY=0, press 10 keys simultaneously for 3 frames -> FIFO fills at 8 and scan stalls (no SCAN_DONE); after EV_READY=1, all 10 events arrive in scan order.
REQ-036 Macro undefined with the same stimulus as REQ-035 -> EV_VALID=0, no stall, SCAN_DONE every 96 cycles, and 10 KEY_STATE bits set.
